ask_modulator: RTL



---
 rtl/ask_modulator.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/ask_modulator.sv
// On-off keyed square-wave modulator fed by a bit FIFO; produces offset-binary
// samples for the DAC driver, holding each bit for SAMPLES_PER_BIT clocks.
module ask_modulator #(
  parameter int         FIFO_DEPTH          = 16,
  parameter int         SAMPLES_PER_BIT     = 16,
  parameter int         CARRIER_HALF_PERIOD = 2,
  parameter logic [7:0] AMPLITUDE           = 8'd127
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          bit_in,
  input  logic                          bit_valid,
  input  logic                          clear_ovf,
  output logic [7:0]                    ask_out,
  output logic                          sample_valid,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
  localparam int DIV_W = (CARRIER_HALF_PERIOD > 1) ? $clog2(CARRIER_HALF_PERIOD) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t               state, state_nxt;
  logic [FIFO_DEPTH-1:0] fifo_mem;
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic                 fifo_empty, fifo_full;
  logic                 pop, push, drop;
  logic                 cur_bit;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 phase;
  logic [DIV_W-1:0]     div;

  function automatic logic [7:0] sat_u8(input logic signed [9:0] v);
    if (v < 10'sd0)
      return 8'd0;
    else if (v > 10'sd255)
      return 8'd255;
    else
      return v[7:0];
  endfunction

  function automatic logic [7:0] carrier_sample(input logic active, input logic ph);
    logic signed [9:0] swing;
    logic signed [9:0] mid;
    mid   = 10'sd128;
    swing = signed'({2'b00, AMPLITUDE});
    if (!active)
      return sat_u8(mid);
    else if (ph)
      return sat_u8(mid + swing);
    else
      return sat_u8(mid - swing);
  endfunction

  assign fifo_empty = (fifo_level == '0);
  assign fifo_full  = (fifo_level == LVL_W'(FIFO_DEPTH));

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (bit_cnt == '0) begin
          if (!fifo_empty)
            pop = 1'b1;
          else
            state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A full FIFO still takes a write when the same edge frees a slot
  assign push = bit_valid && (!fifo_full || pop);
  assign drop = bit_valid && !push;

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= bit_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (drop)
        overflow <= 1'b1;
      else if (clear_ovf)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_bit <= 1'b0;
      bit_cnt <= '0;
    end else if (pop) begin
      cur_bit <= fifo_mem[rd_ptr];
      bit_cnt <= CNT_W'(SAMPLES_PER_BIT - 1);
    end else if (state == SEND && bit_cnt != '0) begin
      bit_cnt <= bit_cnt - CNT_W'(1);
    end
  end

  // Phase restarts only when leaving IDLE; back-to-back bits keep the carrier running
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= 1'b1;
      div   <= '0;
    end else if (state == IDLE && pop) begin
      phase <= 1'b1;
      div   <= '0;
    end else if (state == SEND) begin
      if (div == DIV_W'(CARRIER_HALF_PERIOD - 1)) begin
        div   <= '0;
        phase <= ~phase;
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end

  assign ask_out      = carrier_sample((state == SEND) && cur_bit, phase);
  assign sample_valid = (state == SEND);
  assign tx_busy      = (state == SEND) || !fifo_empty;

endmodule
